// File: rtl/car_pkg.sv
// Shared car constants: screen geometry, heading codes and unit steps.
// Imported by the frame sequencer and by the car drawer.
package car_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int BOX      = 15;

  localparam logic [2:0] DIR_E  = 3'd0;
  localparam logic [2:0] DIR_NE = 3'd1;
  localparam logic [2:0] DIR_N  = 3'd2;
  localparam logic [2:0] DIR_NW = 3'd3;
  localparam logic [2:0] DIR_W  = 3'd4;
  localparam logic [2:0] DIR_SW = 3'd5;
  localparam logic [2:0] DIR_S  = 3'd6;
  localparam logic [2:0] DIR_SE = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_UPDATE,
    S_DRAW_REQ,
    S_DRAW_WAIT
  } seq_state_t;

  // North is decreasing Y.
  function automatic logic signed [1:0] step_dx(input logic [2:0] d);
    case (d)
      DIR_E, DIR_NE, DIR_SE: step_dx = 2'sd1;
      DIR_W, DIR_NW, DIR_SW: step_dx = -2'sd1;
      default:               step_dx = 2'sd0;
    endcase
  endfunction

  function automatic logic signed [1:0] step_dy(input logic [2:0] d);
    case (d)
      DIR_S, DIR_SW, DIR_SE: step_dy = 2'sd1;
      DIR_N, DIR_NW, DIR_NE: step_dy = -2'sd1;
      default:               step_dy = 2'sd0;
    endcase
  endfunction

endpackage

// File: rtl/box_scan.sv
// Raster counter over a SIDE x SIDE box: k with mod/div offsets.
// Offsets presented are those of the position after the current one.
module box_scan
  import car_pkg::*;
#(
  parameter int SIDE = BOX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [3:0] nxt_col,
  output logic [3:0] nxt_row,
  output logic       wrap
);

  localparam logic [7:0] K_LAST = 8'(SIDE * SIDE - 1);
  localparam logic [3:0] C_LAST = 4'(SIDE - 1);

  logic [7:0] k;
  logic [3:0] col;
  logic [3:0] row;

  always_comb begin
    wrap = en && (k == K_LAST);
    if (col == C_LAST) begin
      nxt_col = 4'd0;
      nxt_row = row + 4'd1;
    end else begin
      nxt_col = col + 4'd1;
      nxt_row = row;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k   <= 8'd0;
      col <= 4'd0;
      row <= 4'd0;
    end else if (en) begin
      if (wrap) begin
        k   <= 8'd0;
        col <= 4'd0;
        row <= 4'd0;
      end else begin
        k   <= k + 8'd1;
        col <= nxt_col;
        row <= nxt_row;
      end
    end
  end

endmodule

// File: rtl/car_frame_sequencer.sv
// Per-frame car sequencer: erase old box, move/turn, request redraw.
// Ticks arriving while busy collapse into a single pending flag.
module car_frame_sequencer
  import car_pkg::*;
#(
  parameter int         X_SCREEN_PIXELS = SCREEN_W,
  parameter int         Y_SCREEN_PIXELS = SCREEN_H,
  parameter int         BOX             = car_pkg::BOX,
  parameter logic [8:0] BG_COLOUR       = 9'h000,
  parameter int         START_X         = 72,
  parameter int         START_Y         = 52,
  parameter int         START_DIR       = 2
) (
  input  logic       iClock,
  input  logic       iResetn,
  input  logic       iFrameTick,
  input  logic       iTurnL,
  input  logic       iTurnR,
  input  logic       iGo,
  input  logic       iDrawDone,
  output logic [7:0] oCarX,
  output logic [6:0] oCarY,
  output logic [2:0] oDir,
  output logic       oDrawCar,
  output logic [7:0] oX,
  output logic [6:0] oY,
  output logic [8:0] oColour,
  output logic       oPlot,
  output logic       oBusy
);

  localparam logic [7:0] X_MAX = 8'(X_SCREEN_PIXELS - BOX);
  localparam logic [7:0] Y_MAX = 8'(Y_SCREEN_PIXELS - BOX);

  seq_state_t state, state_n;
  logic       pending, pending_n;
  logic       start, scan_en, wrap;
  logic [3:0] nxt_col, nxt_row;

  box_scan #(.SIDE(BOX)) u_scan (
    .clk     (iClock),
    .rst_n   (iResetn),
    .en      (scan_en),
    .nxt_col (nxt_col),
    .nxt_row (nxt_row),
    .wrap    (wrap)
  );

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      state   <= S_IDLE;
      pending <= 1'b0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
    end
  end

  always_comb begin
    state_n   = state;
    pending_n = pending | iFrameTick;
    case (state)
      S_IDLE: begin
        if (iFrameTick || pending) begin
          state_n   = S_ERASE;
          pending_n = 1'b0;
        end
      end
      S_ERASE:     if (wrap) state_n = S_UPDATE;
      S_UPDATE:    state_n = S_DRAW_REQ;
      S_DRAW_REQ:  state_n = S_DRAW_WAIT;
      S_DRAW_WAIT: if (iDrawDone) state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
    start    = (state == S_IDLE) && (state_n == S_ERASE);
    scan_en  = (state == S_ERASE);
    oBusy    = (state != S_IDLE);
    oDrawCar = (state == S_DRAW_REQ);
  end

  // Next heading and clamped position, evaluated in UPDATE only.
  logic [2:0]        dir_n;
  logic signed [1:0] dx, dy;
  logic signed [8:0] px, py;
  logic [7:0]        x_n;
  logic [6:0]        y_n;

  always_comb begin
    dir_n = oDir;
    if (iTurnL && !iTurnR)
      dir_n = oDir + 3'd1;
    else if (iTurnR && !iTurnL)
      dir_n = oDir - 3'd1;
    dx = step_dx(dir_n);
    dy = step_dy(dir_n);
    px = $signed({1'b0, oCarX});
    py = $signed({2'b0, oCarY});
    if (iGo) begin
      px = px + $signed({{7{dx[1]}}, dx});
      py = py + $signed({{7{dy[1]}}, dy});
    end
    if (px[8])
      x_n = 8'd0;
    else if (px[7:0] > X_MAX)
      x_n = X_MAX;
    else
      x_n = px[7:0];
    if (py[8])
      y_n = 7'd0;
    else if (py[7:0] > Y_MAX)
      y_n = Y_MAX[6:0];
    else
      y_n = py[6:0];
  end

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      oCarX <= 8'(START_X);
      oCarY <= 7'(START_Y);
      oDir  <= 3'(START_DIR);
    end else if (state == S_UPDATE) begin
      oCarX <= x_n;
      oCarY <= y_n;
      oDir  <= dir_n;
    end
  end

  // Pixel k is loaded on the edge entering its cycle, so oPlot tracks ERASE.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      oX      <= 8'd0;
      oY      <= 7'd0;
      oColour <= 9'd0;
      oPlot   <= 1'b0;
    end else begin
      oPlot <= start | (scan_en & ~wrap);
      if (start) begin
        oX      <= oCarX;
        oY      <= oCarY;
        oColour <= BG_COLOUR;
      end else if (scan_en && !wrap) begin
        oX <= oCarX + {4'b0, nxt_col};
        oY <= oCarY + {3'b0, nxt_row};
      end
    end
  end

endmodule

// File: tb/tb_car_frame_sequencer.sv
// Scoreboard bench for car_frame_sequencer: directed frames,
// expected pixels/draws queued by stimulus, popped by a monitor.
module tb_car_frame_sequencer;

  logic       iClock = 1'b0;
  logic       iResetn = 1'b0;
  logic       iFrameTick = 1'b0;
  logic       iTurnL = 1'b0;
  logic       iTurnR = 1'b0;
  logic       iGo = 1'b0;
  logic       iDrawDone = 1'b0;
  logic [7:0] oCarX;
  logic [6:0] oCarY;
  logic [2:0] oDir;
  logic       oDrawCar;
  logic [7:0] oX;
  logic [6:0] oY;
  logic [8:0] oColour;
  logic       oPlot;
  logic       oBusy;

  car_frame_sequencer dut (
    .iClock     (iClock),
    .iResetn    (iResetn),
    .iFrameTick (iFrameTick),
    .iTurnL     (iTurnL),
    .iTurnR     (iTurnR),
    .iGo        (iGo),
    .iDrawDone  (iDrawDone),
    .oCarX      (oCarX),
    .oCarY      (oCarY),
    .oDir       (oDir),
    .oDrawCar   (oDrawCar),
    .oX         (oX),
    .oY         (oY),
    .oColour    (oColour),
    .oPlot      (oPlot),
    .oBusy      (oBusy)
  );

  always #5 iClock = ~iClock;

  int n_pass = 0;
  int n_total = 0;
  int q_pix[$];
  int q_draw[$];
  int mx = 72, my = 52, md = 2;
  int done_delay = 2;
  int resp_d;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: queue erase pixels, then move/turn and queue the draw.
  task automatic model_frame(input logic l, input logic r, input logic g);
    int dx, dy;
    for (int k = 0; k < 225; k++)
      q_pix.push_back(((mx + k % 15) << 16) | ((my + k / 15) << 9));
    if (l && !r) md = (md + 1) % 8;
    else if (r && !l) md = (md + 7) % 8;
    if (g) begin
      case (md)
        0: begin dx = 1;  dy = 0;  end
        1: begin dx = 1;  dy = -1; end
        2: begin dx = 0;  dy = -1; end
        3: begin dx = -1; dy = -1; end
        4: begin dx = -1; dy = 0;  end
        5: begin dx = -1; dy = 1;  end
        6: begin dx = 0;  dy = 1;  end
        default: begin dx = 1; dy = 1; end
      endcase
      mx = mx + dx;
      my = my + dy;
      if (mx < 0) mx = 0;
      if (mx > 145) mx = 145;
      if (my < 0) my = 0;
      if (my > 105) my = 105;
    end
    q_draw.push_back((mx << 10) | (my << 3) | md);
  endtask

  task automatic pulse_tick();
    @(posedge iClock) #1 iFrameTick = 1'b1;
    @(posedge iClock) #1 iFrameTick = 1'b0;
  endtask

  task automatic run_frame(input logic l, input logic r, input logic g);
    bit ok = 0;
    model_frame(l, r, g);
    @(posedge iClock) #1;
    iTurnL = l;
    iTurnR = r;
    iGo = g;
    pulse_tick();
    for (int i = 0; i < 2000; i++) begin
      @(negedge iClock);
      if (!oBusy) begin ok = 1; break; end
    end
    chk("frame_complete", int'(ok), 1);
  endtask

  // Drawer model: acknowledges each draw request after done_delay cycles.
  initial begin
    forever begin
      @(negedge iClock);
      if (iResetn && oDrawCar) begin
        resp_d = done_delay;
        repeat (resp_d) @(posedge iClock);
        #1 iDrawDone = 1'b1;
        @(posedge iClock) #1 iDrawDone = 1'b0;
      end
    end
  end

  always @(negedge iClock) begin
    if (iResetn) begin
      if (oPlot) begin
        if (q_pix.size() == 0) chk("unexpected_plot", {oX, oY, oColour}, -1);
        else chk("erase_pixel", {oX, oY, oColour}, q_pix.pop_front());
      end
      if (oDrawCar) begin
        if (q_draw.size() == 0) chk("unexpected_draw", {oCarX, oCarY, oDir}, -1);
        else chk("draw_request", {oCarX, oCarY, oDir}, q_draw.pop_front());
      end
    end
  end

  initial begin
    bit ok;
    repeat (3) @(posedge iClock);
    #1;
    chk("rst_carx", oCarX, 72);
    chk("rst_cary", oCarY, 52);
    chk("rst_dir", oDir, 2);
    chk("rst_xyc", {oX, oY, oColour}, 0);
    chk("rst_plot", oPlot, 0);
    chk("rst_draw", oDrawCar, 0);
    chk("rst_busy", oBusy, 0);
    iResetn = 1'b1;

    run_frame(0, 0, 0);
    for (int f = 0; f < 10; f++) run_frame(0, 0, 1);
    chk("ten_frames_y", oCarY, 42);
    chk("ten_frames_x", oCarX, 72);

    for (int f = 0; f < 3; f++) run_frame(0, 1, 0);
    chk("turn_to_se", oDir, 7);
    for (int f = 0; f < 80; f++) run_frame(0, 0, 1);
    chk("clamp_max", {oCarX, oCarY}, {8'd145, 7'd105});

    for (int f = 0; f < 4; f++) run_frame(1, 0, 0);
    chk("turn_to_nw", oDir, 3);
    for (int f = 0; f < 150; f++) run_frame(0, 0, 1);
    chk("clamp_min", {oCarX, oCarY}, 0);

    run_frame(0, 1, 0);
    for (int f = 0; f < 9; f++) run_frame(1, 0, 0);
    chk("turnl_nine", oDir, 3);
    for (int f = 0; f < 2; f++) run_frame(1, 1, 0);
    chk("turn_both", oDir, 3);

    // Three ticks during one slow DRAW_WAIT yield exactly one more frame.
    done_delay = 500;
    model_frame(0, 0, 0);
    @(posedge iClock) #1;
    iTurnL = 0; iTurnR = 0; iGo = 0;
    pulse_tick();
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge iClock);
      if (oDrawCar) begin ok = 1; break; end
    end
    chk("slow_draw_seen", int'(ok), 1);
    #2 done_delay = 2;
    model_frame(0, 0, 0);
    repeat (3) begin
      repeat (50) @(posedge iClock);
      #1 iFrameTick = 1'b1;
      @(posedge iClock) #1 iFrameTick = 1'b0;
    end
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge iClock);
      if (iDrawDone) begin ok = 1; break; end
    end
    chk("slow_done_seen", int'(ok), 1);
    @(negedge iClock);
    chk("idle_one_cycle", oBusy, 0);
    @(negedge iClock);
    chk("pending_restart_busy", oBusy, 1);
    chk("pending_restart_plot", oPlot, 1);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge iClock);
      if (!oBusy) begin ok = 1; break; end
    end
    chk("pending_frame_done", int'(ok), 1);
    repeat (300) @(posedge iClock);
    chk("no_extra_frames", q_pix.size() + q_draw.size(), 0);

    // Reset in the middle of ERASE at k = 100.
    model_frame(0, 0, 0);
    @(posedge iClock) #1;
    pulse_tick();
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge iClock);
      #2;
      if (q_pix.size() == 125) begin ok = 1; break; end
    end
    chk("reach_k100", int'(ok), 1);
    @(posedge iClock) #1;
    chk("plot_before_reset", oPlot, 1);
    iResetn = 1'b0;
    #1;
    chk("mid_rst_plot", oPlot, 0);
    chk("mid_rst_busy", oBusy, 0);
    chk("mid_rst_pos", {oCarX, oCarY}, {8'd72, 7'd52});
    chk("mid_rst_dir", oDir, 2);
    chk("mid_rst_xyc", {oX, oY, oColour}, 0);
    q_pix.delete();
    q_draw.delete();
    mx = 72; my = 52; md = 2;
    repeat (2) @(posedge iClock);
    #1 iResetn = 1'b1;
    repeat (300) @(posedge iClock);
    #1;
    chk("post_rst_quiet", oBusy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
